// File: rtl/pifo_dequeue_agent_if.sv
// Calendar pop/top/count side plus the dequeued-address stream of the PIFO dequeue agent.
// The master modport is the agent; the slave modport is the calendar plus buffer reader.
interface pifo_dequeue_agent_if #(
  parameter int PIFO_INFO_WIDTH           = 32,
  parameter int BUFFER_ADDR_WIDTH         = 12,
  parameter int PIFO_CALENDAR_INDEX_WIDTH = 32
);
  logic [PIFO_INFO_WIDTH-1:0]           s_calendar_top;
  logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] s_calendar_count;
  logic [BUFFER_ADDR_WIDTH-1:0]         s_calendar_buffer_addr;
  logic                                 m_pop_en;
  logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] m_global_time;
  logic [BUFFER_ADDR_WIDTH-1:0]         m_axis_addr_tdata;
  logic                                 m_axis_addr_tvalid;
  logic                                 m_axis_addr_tready;

  modport master (
    input  s_calendar_top, s_calendar_count, s_calendar_buffer_addr, m_axis_addr_tready,
    output m_pop_en, m_global_time, m_axis_addr_tdata, m_axis_addr_tvalid
  );

  modport slave (
    output s_calendar_top, s_calendar_count, s_calendar_buffer_addr, m_axis_addr_tready,
    input  m_pop_en, m_global_time, m_axis_addr_tdata, m_axis_addr_tvalid
  );
endinterface

// File: rtl/pifo_dequeue_agent.sv
// PIFO dequeue agent: owns virtual time, pops the calendar head once its rank is due,
// and presents each popped buffer address on a single-entry valid/ready output register.
module pifo_dequeue_agent #(
  parameter int PIFO_INFO_WIDTH           = 32,
  parameter int BUFFER_ADDR_WIDTH         = 12,
  parameter int PIFO_CALENDAR_INDEX_WIDTH = 32,
  parameter int POP_LATENCY               = 1,
  parameter int TIME_DIV                  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause,
  output logic [31:0] pop_count,
  pifo_dequeue_agent_if.master bus
);
  localparam int          RW       = PIFO_INFO_WIDTH - BUFFER_ADDR_WIDTH;
  localparam logic [15:0] DIV_LAST = 16'(TIME_DIV - 1);
  localparam logic [2:0]  LAT      = 3'(POP_LATENCY);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t                       r_state;
  logic [15:0]                  r_presc;
  logic [RW-1:0]                r_time;
  logic [2:0]                   r_wait;
  logic [BUFFER_ADDR_WIDTH-1:0] r_tdata;
  logic                         r_tvalid;
  logic [31:0]                  r_pop_count;

  logic [RW-1:0] w_rank;
  logic          w_elig;
  logic          w_unused;

  assign w_rank   = bus.s_calendar_top[PIFO_INFO_WIDTH-1:BUFFER_ADDR_WIDTH];
  assign w_unused = ^bus.s_calendar_top[BUFFER_ADDR_WIDTH-1:0];

  // Plain unsigned compare: after time wraps, a large-rank head waits for time to catch up.
  assign w_elig = (bus.s_calendar_count != '0) && (w_rank <= r_time) && !pause && !r_tvalid;

  assign bus.m_pop_en           = (r_state == ST_IDLE) && w_elig;
  assign bus.m_global_time      = PIFO_CALENDAR_INDEX_WIDTH'(r_time);
  assign bus.m_axis_addr_tdata  = r_tdata;
  assign bus.m_axis_addr_tvalid = r_tvalid;
  assign pop_count              = r_pop_count;

  // Virtual-time prescaler; both prescaler and time freeze while paused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= 16'd0;
      r_time  <= '0;
    end else if (!pause) begin
      if (r_presc == DIV_LAST) begin
        r_presc <= 16'd0;
        r_time  <= r_time + RW'(1);
      end else begin
        r_presc <= r_presc + 16'd1;
      end
    end
  end

  // Pop sequencer and output register; an issued pop always completes, pause notwithstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_wait      <= 3'd0;
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_pop_count <= 32'd0;
    end else begin
      if (r_tvalid && bus.m_axis_addr_tready) begin
        r_tvalid    <= 1'b0;
        r_pop_count <= r_pop_count + 32'd1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_elig) begin
            r_wait  <= LAT;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // The output register is empty here, so the capture never collides with a handshake.
          if (r_wait == 3'd1) begin
            r_tdata  <= bus.s_calendar_buffer_addr;
            r_tvalid <= 1'b1;
            r_state  <= ST_IDLE;
          end else begin
            r_wait <= r_wait - 3'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pifo_dequeue_agent.sv
// Bench for pifo_dequeue_agent: a queue-based calendar plus a cycle-count reference model of
// virtual time, pop eligibility and the single-entry output register.
`timescale 1ns/1ps
module tb_pifo_dequeue_agent;
  localparam int IW = 32, AW = 12, CW = 32, PL = 1, TD = 4, RW = IW - AW;
  localparam int W_IW = 16, W_TD = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pause = 1'b0;
  logic        w_pause = 1'b0;
  logic [31:0] pop_count, w_pop_count;
  int          n_checks = 0, n_fail = 0;

  pifo_dequeue_agent_if #(.PIFO_INFO_WIDTH(IW), .BUFFER_ADDR_WIDTH(AW), .PIFO_CALENDAR_INDEX_WIDTH(CW)) bus ();
  pifo_dequeue_agent_if #(.PIFO_INFO_WIDTH(W_IW), .BUFFER_ADDR_WIDTH(AW), .PIFO_CALENDAR_INDEX_WIDTH(CW)) wbus ();

  pifo_dequeue_agent #(.PIFO_INFO_WIDTH(IW), .BUFFER_ADDR_WIDTH(AW), .PIFO_CALENDAR_INDEX_WIDTH(CW),
                       .POP_LATENCY(PL), .TIME_DIV(TD))
    dut (.clk(clk), .rst(rst), .pause(pause), .pop_count(pop_count), .bus(bus));

  pifo_dequeue_agent #(.PIFO_INFO_WIDTH(W_IW), .BUFFER_ADDR_WIDTH(AW), .PIFO_CALENDAR_INDEX_WIDTH(CW),
                       .POP_LATENCY(1), .TIME_DIV(W_TD))
    dut_w (.clk(clk), .rst(rst), .pause(w_pause), .pop_count(w_pop_count), .bus(wbus));

  always #5 clk = ~clk;

  // Calendar model: ranks kept sorted, FIFO among equal ranks.
  int unsigned     cal_rank[$];
  logic [AW-1:0]   cal_addr[$];

  // Reference model state.
  int            cyc, m_active, m_pop_cyc;
  bit            m_inflight, m_valid, exp_pop;
  logic [AW-1:0] m_data;
  logic [31:0]   m_cnt, exp_gt;
  logic [77:0]   obs_vec, exp_vec;

  task automatic drive_cal();
    bus.s_calendar_count = 32'(cal_rank.size());
    if (cal_rank.size() != 0) bus.s_calendar_top = {RW'(cal_rank[0]), cal_addr[0]};
    else                      bus.s_calendar_top = $urandom();
  endtask

  task automatic push(input int unsigned rk, input logic [AW-1:0] ad);
    int pos;
    pos = cal_rank.size();
    for (int i = 0; i < cal_rank.size(); i++)
      if (pos == cal_rank.size() && cal_rank[i] > rk) pos = i;
    cal_rank.insert(pos, rk);
    cal_addr.insert(pos, ad);
  endtask

  task automatic evaluate();
    #1;
    exp_gt  = 32'(RW'(m_active / TD));
    exp_pop = !m_inflight && !m_valid && !pause &&
              ((cal_rank.size() != 0) ? (cal_rank[0] <= exp_gt) : 1'b0);
    obs_vec = {bus.m_pop_en, bus.m_axis_addr_tvalid, bus.m_axis_addr_tdata, bus.m_global_time, pop_count};
    exp_vec = {exp_pop, m_valid, m_data, exp_gt, m_cnt};
  endtask

  // Advance one clock: apply the model's edge update, then set up the next cycle's inputs.
  task automatic cyc_run(input bit p, input bit r, input bit do_push, input int unsigned rk,
                         input logic [AW-1:0] ad);
    bit popped;
    popped = bus.m_pop_en;
    if (m_valid && bus.m_axis_addr_tready) begin
      m_valid = 1'b0;
      m_cnt   = m_cnt + 32'd1;
    end
    if (m_inflight && cyc == m_pop_cyc + PL) begin
      m_valid    = 1'b1;
      m_data     = bus.s_calendar_buffer_addr;
      m_inflight = 1'b0;
    end
    if (exp_pop) begin
      m_inflight = 1'b1;
      m_pop_cyc  = cyc;
    end
    if (!pause) m_active++;
    @(posedge clk);
    #1;
    cyc++;
    if (popped && cal_rank.size() != 0) begin
      bus.s_calendar_buffer_addr = cal_addr[0];
      void'(cal_rank.pop_front());
      void'(cal_addr.pop_front());
    end
    if (do_push) push(rk, ad);
    pause = p;
    bus.m_axis_addr_tready = r;
    drive_cal();
    evaluate();
  endtask

  task automatic reset_assert();
    rst = 1'b1;
    pause = 1'b0;
    bus.m_axis_addr_tready = 1'b1;
    cal_rank.delete();
    cal_addr.delete();
    drive_cal();
  endtask

  task automatic reset_release();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0; m_active = 0; m_pop_cyc = 0;
    m_inflight = 1'b0; m_valid = 1'b0; m_data = '0; m_cnt = 32'd0;
    drive_cal();
    evaluate();
  endtask

  task automatic test_reset();
    reset_assert();
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #2;
      n_checks++;
      if ({bus.m_pop_en, bus.m_axis_addr_tvalid, bus.m_axis_addr_tdata, bus.m_global_time, pop_count,
           wbus.m_axis_addr_tvalid, wbus.m_global_time} !== 111'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: got pop=%b v=%b d=%h t=%0d n=%0d, required all 0",
                 bus.m_pop_en, bus.m_axis_addr_tvalid, bus.m_axis_addr_tdata, bus.m_global_time, pop_count);
      end
    end
    reset_release();
    for (int k = 1; k <= 8; k++) begin
      cyc_run(1'b0, 1'b1, 1'b0, 0, '0);
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++; $display("FAIL reset_model cyc=%0d got %h required %h", cyc, obs_vec, exp_vec);
      end
      if (k == 4 || k == 8) begin
        n_checks++;
        if (bus.m_global_time !== 32'(k / 4)) begin
          n_fail++; $display("FAIL reset_time cyc=%0d got %0d required %0d", k, bus.m_global_time, k / 4);
        end
      end
    end
  endtask

  task automatic test_single();
    int pops;
    reset_assert();
    push(0, 12'h05A);
    reset_release();
    pops = 0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) cyc_run(1'b0, 1'b1, 1'b0, 0, '0);
      pops += int'(bus.m_pop_en);
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++; $display("FAIL single_model cyc=%0d got %h required %h", cyc, obs_vec, exp_vec);
      end
      if (k == 0 || k == 2 || k == 3) begin
        n_checks++;
        if ((k == 0 && bus.m_pop_en !== 1'b1) ||
            (k == 2 && {bus.m_axis_addr_tvalid, bus.m_axis_addr_tdata} !== {1'b1, 12'h05A}) ||
            (k == 3 && pop_count !== 32'd1)) begin
          n_fail++;
          $display("FAIL single_step cyc=%0d got pop=%b v=%b d=%h n=%0d", k, bus.m_pop_en,
                   bus.m_axis_addr_tvalid, bus.m_axis_addr_tdata, pop_count);
        end
      end
    end
    n_checks++;
    if (pops != 1) begin
      n_fail++; $display("FAIL single_pop_count got %0d pops required 1", pops);
    end
  endtask

  task automatic test_rank_gate();
    int first_cyc;
    logic [31:0] first_time;
    reset_assert();
    push(5, 12'($urandom()));
    reset_release();
    first_cyc = -1;
    first_time = 32'hFFFF_FFFF;
    for (int k = 0; k < 26; k++) begin
      if (k > 0) cyc_run(1'b0, 1'b1, 1'b0, 0, '0);
      if (bus.m_pop_en === 1'b1 && first_cyc < 0) begin
        first_cyc = cyc;
        first_time = bus.m_global_time;
      end
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++; $display("FAIL rank_model cyc=%0d got %h required %h", cyc, obs_vec, exp_vec);
      end
    end
    n_checks++;
    if (first_cyc != 20 || first_time !== 32'd5) begin
      n_fail++; $display("FAIL rank_gate first pop cyc=%0d time=%0d required cyc 20 time 5", first_cyc, first_time);
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] a0;
    a0 = 12'($urandom());
    reset_assert();
    push(0, a0);
    push(0, 12'($urandom()));
    push(0, 12'($urandom()));
    bus.m_axis_addr_tready = 1'b0;
    reset_release();
    for (int k = 1; k <= 16; k++) begin
      cyc_run(1'b0, (k == 13), 1'b0, 0, '0);
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++; $display("FAIL bp_model cyc=%0d got %h required %h", cyc, obs_vec, exp_vec);
      end
      if (k >= 2 && k <= 14) begin
        n_checks++;
        if ((k <= 13 && {bus.m_pop_en, bus.m_axis_addr_tvalid, bus.m_axis_addr_tdata} !== {1'b0, 1'b1, a0}) ||
            (k == 14 && {bus.m_pop_en, bus.m_axis_addr_tvalid} !== 2'b10)) begin
          n_fail++;
          $display("FAIL bp_hold cyc=%0d got pop=%b v=%b d=%h (addr %h)", k, bus.m_pop_en,
                   bus.m_axis_addr_tvalid, bus.m_axis_addr_tdata, a0);
        end
      end
    end
  endtask

  task automatic test_pause();
    reset_assert();
    push(2, 12'($urandom()));
    push(2, 12'($urandom()));
    push(3, 12'($urandom()));
    reset_release();
    for (int k = 1; k <= 40; k++) begin
      cyc_run((k >= 12 && k <= 31), 1'b1, 1'b0, 0, '0);
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++; $display("FAIL pause_model cyc=%0d got %h required %h", cyc, obs_vec, exp_vec);
      end
      if ((k >= 12 && k <= 36) || k == 13) begin
        n_checks++;
        if ((k <= 35 && bus.m_global_time !== 32'd3) || (k == 36 && bus.m_global_time !== 32'd4) ||
            (k <= 31 && bus.m_pop_en !== 1'b0) || (k == 13 && bus.m_axis_addr_tvalid !== 1'b1) ||
            (k == 32 && bus.m_pop_en !== 1'b1)) begin
          n_fail++;
          $display("FAIL pause_step cyc=%0d got t=%0d pop=%b v=%b", k, bus.m_global_time,
                   bus.m_pop_en, bus.m_axis_addr_tvalid);
        end
      end
    end
  endtask

  task automatic test_empty();
    int pops;
    reset_assert();
    reset_release();
    pops = 0;
    for (int k = 1; k <= 100; k++) begin
      cyc_run(1'b0, 1'($urandom()), 1'b0, 0, '0);
      pops += int'(bus.m_pop_en);
    end
    n_checks++;
    if (pops != 0 || bus.m_axis_addr_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL empty_no_pop got %0d pops v=%b required 0", pops, bus.m_axis_addr_tvalid);
    end
  endtask

  task automatic test_reset_mid();
    reset_assert();
    push(0, 12'($urandom()));
    reset_release();
    cyc_run(1'b0, 1'b1, 1'b0, 0, '0);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.m_axis_addr_tvalid, bus.m_axis_addr_tdata, bus.m_global_time} !== 45'd0) begin
      n_fail++; $display("FAIL reset_mid got v=%b d=%h t=%0d required 0", bus.m_axis_addr_tvalid,
                         bus.m_axis_addr_tdata, bus.m_global_time);
    end
    @(posedge clk);
    #2;
    n_checks++;
    if (bus.m_axis_addr_tvalid !== 1'b0 || pop_count !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid_discard got v=%b n=%0d required 0", bus.m_axis_addr_tvalid, pop_count);
    end
  endtask

  task automatic test_random();
    bit dp;
    reset_assert();
    reset_release();
    for (int k = 1; k <= 600; k++) begin
      dp = ($urandom_range(0, 2) == 0) && (cal_rank.size() < 8);
      cyc_run(($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0), dp,
              exp_gt + $urandom_range(0, 5), 12'($urandom()));
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++; $display("FAIL random_model cyc=%0d got %h required %h", cyc, obs_vec, exp_vec);
      end
    end
  endtask

  // Four-bit time, one tick per cycle: time equals the cycle index modulo 16.
  task automatic test_wrap();
    logic [AW-1:0] a1, a2;
    a1 = 12'($urandom());
    a2 = 12'($urandom());
    reset_assert();
    wbus.s_calendar_count = 32'd1;
    wbus.s_calendar_top = {4'd15, a1};
    wbus.s_calendar_buffer_addr = '0;
    wbus.m_axis_addr_tready = 1'b1;
    reset_release();
    for (int k = 0; k < 40; k++) begin
      n_checks++;
      if ({wbus.m_pop_en, wbus.m_global_time} !== {(k == 15 || k == 30), 32'(k % 16)}) begin
        n_fail++; $display("FAIL wrap_step cyc=%0d got pop=%b t=%0d required pop=%b t=%0d", k,
                           wbus.m_pop_en, wbus.m_global_time, (k == 15 || k == 30), k % 16);
      end
      if (k == 17 || k == 32) begin
        n_checks++;
        if ({wbus.m_axis_addr_tvalid, wbus.m_axis_addr_tdata} !== {1'b1, (k == 17) ? a1 : a2}) begin
          n_fail++; $display("FAIL wrap_data cyc=%0d got v=%b d=%h", k, wbus.m_axis_addr_tvalid, wbus.m_axis_addr_tdata);
        end
      end
      @(posedge clk);
      #1;
      if (k == 15) begin
        wbus.s_calendar_top = {4'd14, a2};
        wbus.s_calendar_buffer_addr = a1;
      end
      if (k == 30) begin
        wbus.s_calendar_count = 32'd0;
        wbus.s_calendar_buffer_addr = a2;
      end
      #1;
    end
    wbus.s_calendar_count = 32'd0;
  endtask

  initial begin
    wbus.s_calendar_count = 32'd0;
    wbus.s_calendar_top = '0;
    wbus.s_calendar_buffer_addr = '0;
    wbus.m_axis_addr_tready = 1'b1;
    bus.s_calendar_buffer_addr = '0;
    bus.m_axis_addr_tready = 1'b1;
    drive_cal();
    #3;
    test_reset();
    test_single();
    test_rank_gate();
    test_backpressure();
    test_pause();
    test_empty();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
